// File: rtl/layer_pkg.sv
// Shared definitions for the layer datapath: FSM state codes, accumulator
// sizing and the activation saturation bounds.
package layer_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_FETCH = 3'd1;
    localparam logic [STATE_W-1:0] ST_MAC   = 3'd2;
    localparam logic [STATE_W-1:0] ST_BIAS  = 3'd3;
    localparam logic [STATE_W-1:0] ST_ACT   = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;

    localparam int SAT_MIN = 0;

    // Wide enough for NO_IPN full-scale products plus one sign-extended bias.
    function automatic int acc_width(input int dw, input int ipn);
        return 2 * dw + $clog2(ipn) + 1;
    endfunction

    function automatic int sat_max(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

endpackage

// File: rtl/layer_datapath_if.sv
// Read port between the layer datapath (master) and the input/weight memory (slave).
interface layer_datapath_if #(
    parameter int NO_NPL = 4,
    parameter int NO_IPN = 4,
    parameter int DW     = 8
);
    import layer_pkg::*;

    logic                         mem_req;
    logic [$clog2(NO_IPN):0]      mem_addr;
    logic                         mem_rvalid;
    logic [DW*(NO_NPL+1)-1:0]     mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rvalid,
        output mem_rdata
    );

endinterface

// File: rtl/layer_datapath_relu_sat.sv
// ReLU activation with saturation of a signed accumulator into [0, 2^(DW-1)-1].
module relu_sat
    import layer_pkg::*;
#(
    parameter int AW = 19,
    parameter int DW = 8
) (
    input  logic signed [AW-1:0] acc,
    output logic        [DW-1:0] y
);

    localparam logic signed [AW-1:0] MAX_V = AW'(sat_max(DW));
    localparam logic signed [AW-1:0] MIN_V = AW'(SAT_MIN);

    always_comb begin
        if (acc < MIN_V) begin
            y = MIN_V[DW-1:0];
        end else if (acc > MAX_V) begin
            y = MAX_V[DW-1:0];
        end else begin
            y = acc[DW-1:0];
        end
    end

endmodule

// File: rtl/layer_datapath.sv
// One neural-network layer: fetch inputs and weights, multiply-accumulate,
// add biases and apply a saturating ReLU, stepped by controller strobes.
module layer_datapath
    import layer_pkg::*;
#(
    parameter int NO_NPL = 4,
    parameter int NO_IPN = 4,
    parameter int DW     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arb_en,
    input  logic                   mac_en,
    input  logic                   bias_add_en,
    input  logic                   act_fn_en,
    layer_datapath_if.master       mem,
    input  logic [DW*NO_NPL-1:0]   bias_data,
    output logic [DW*NO_NPL-1:0]   out_data,
    output logic                   out_valid,
    output logic                   seq_err
);

    localparam int AW = acc_width(DW, NO_IPN);
    localparam int CW = $clog2(NO_IPN) + 1;
    localparam int NW = $clog2(NO_NPL) + 1;

    logic [STATE_W-1:0]   state_q, state_d;
    logic [CW-1:0]        req_cnt_q, req_cnt_d;
    logic [CW-1:0]        rsp_cnt_q, rsp_cnt_d;
    logic [CW-1:0]        mac_idx_q, mac_idx_d;
    logic [NW-1:0]        node_idx_q, node_idx_d;
    logic signed [DW-1:0] x_buf_q [NO_IPN];
    logic signed [DW-1:0] x_buf_d [NO_IPN];
    logic signed [DW-1:0] w_buf_q [NO_IPN][NO_NPL];
    logic signed [DW-1:0] w_buf_d [NO_IPN][NO_NPL];
    logic signed [AW-1:0] acc_q [NO_NPL];
    logic signed [AW-1:0] acc_d [NO_NPL];
    logic [DW*NO_NPL-1:0] out_data_q, out_data_d;
    logic                 seq_err_q, seq_err_d;

    logic                   mem_req;
    logic signed [DW-1:0]   mac_x;
    logic signed [DW-1:0]   mac_w [NO_NPL];
    logic signed [2*DW-1:0] prod [NO_NPL];
    logic signed [DW-1:0]   bias_sel;
    logic signed [AW-1:0]   act_in;
    logic [DW-1:0]          act_out;

    relu_sat #(.AW(AW), .DW(DW)) u_relu_sat (
        .acc (act_in),
        .y   (act_out)
    );

    assign mem_req      = (state_q == ST_FETCH) && (req_cnt_q < CW'(NO_IPN));
    assign mem.mem_req  = mem_req;
    assign mem.mem_addr = mem_req ? req_cnt_q : '0;
    assign out_data     = out_data_q;
    assign out_valid    = (state_q == ST_DONE);
    assign seq_err      = seq_err_q;

    // Operand selection by the current MAC index and node index.
    always_comb begin
        mac_x    = '0;
        mac_w    = '{default: '0};
        bias_sel = '0;
        act_in   = '0;
        for (int i = 0; i < NO_IPN; i++) begin
            if (mac_idx_q == CW'(i)) begin
                mac_x = x_buf_q[i];
                for (int n = 0; n < NO_NPL; n++) mac_w[n] = w_buf_q[i][n];
            end
        end
        for (int n = 0; n < NO_NPL; n++) begin
            if (node_idx_q == NW'(n)) begin
                bias_sel = bias_data[n*DW +: DW];
                act_in   = acc_q[n];
            end
        end
        for (int n = 0; n < NO_NPL; n++) prod[n] = mac_x * mac_w[n];
    end

    always_comb begin
        state_d    = state_q;
        req_cnt_d  = req_cnt_q;
        rsp_cnt_d  = rsp_cnt_q;
        mac_idx_d  = mac_idx_q;
        node_idx_d = node_idx_q;
        x_buf_d    = x_buf_q;
        w_buf_d    = w_buf_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        seq_err_d  = seq_err_q;

        // Strobes arriving outside their own phase are dropped but remembered.
        if (arb_en && (state_q != ST_IDLE) && (state_q != ST_DONE)) seq_err_d = 1'b1;
        if (mac_en && (state_q != ST_MAC))                          seq_err_d = 1'b1;
        if (bias_add_en && (state_q != ST_BIAS))                    seq_err_d = 1'b1;
        if (act_fn_en && (state_q != ST_ACT))                       seq_err_d = 1'b1;
        if (mem.mem_rvalid && ((state_q != ST_FETCH) || (rsp_cnt_q >= CW'(NO_IPN))))
            seq_err_d = 1'b1;

        if (mem_req) req_cnt_d = req_cnt_q + 1'b1;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arb_en) begin
                    state_d    = ST_FETCH;
                    req_cnt_d  = '0;
                    rsp_cnt_d  = '0;
                    mac_idx_d  = '0;
                    node_idx_d = '0;
                    acc_d      = '{default: '0};
                end
            end
            ST_FETCH: begin
                if (mem.mem_rvalid && (rsp_cnt_q < CW'(NO_IPN))) begin
                    for (int i = 0; i < NO_IPN; i++) begin
                        if (rsp_cnt_q == CW'(i)) begin
                            x_buf_d[i] = mem.mem_rdata[DW-1:0];
                            for (int n = 0; n < NO_NPL; n++)
                                w_buf_d[i][n] = mem.mem_rdata[(n+1)*DW +: DW];
                        end
                    end
                    rsp_cnt_d = rsp_cnt_q + 1'b1;
                    if (rsp_cnt_q == CW'(NO_IPN - 1)) state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                if (mac_en) begin
                    for (int n = 0; n < NO_NPL; n++)
                        acc_d[n] = acc_q[n] + {{(AW-2*DW){prod[n][2*DW-1]}}, prod[n]};
                    mac_idx_d = mac_idx_q + 1'b1;
                    if (mac_idx_q == CW'(NO_IPN - 1)) begin
                        state_d    = ST_BIAS;
                        node_idx_d = '0;
                    end
                end
            end
            ST_BIAS: begin
                if (bias_add_en) begin
                    for (int n = 0; n < NO_NPL; n++)
                        if (node_idx_q == NW'(n))
                            acc_d[n] = acc_q[n] + {{(AW-DW){bias_sel[DW-1]}}, bias_sel};
                    node_idx_d = node_idx_q + 1'b1;
                    if (node_idx_q == NW'(NO_NPL - 1)) begin
                        state_d    = ST_ACT;
                        node_idx_d = '0;
                    end
                end
            end
            ST_ACT: begin
                if (act_fn_en) begin
                    for (int n = 0; n < NO_NPL; n++)
                        if (node_idx_q == NW'(n)) out_data_d[n*DW +: DW] = act_out;
                    node_idx_d = node_idx_q + 1'b1;
                    if (node_idx_q == NW'(NO_NPL - 1)) state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            req_cnt_q  <= '0;
            rsp_cnt_q  <= '0;
            mac_idx_q  <= '0;
            node_idx_q <= '0;
            x_buf_q    <= '{default: '0};
            w_buf_q    <= '{default: '0};
            acc_q      <= '{default: '0};
            out_data_q <= '0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_cnt_q  <= req_cnt_d;
            rsp_cnt_q  <= rsp_cnt_d;
            mac_idx_q  <= mac_idx_d;
            node_idx_q <= node_idx_d;
            x_buf_q    <= x_buf_d;
            w_buf_q    <= w_buf_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            seq_err_q  <= seq_err_d;
        end
    end

endmodule

// File: tb/tb_layer_datapath.sv
// Directed bench for layer_datapath: table of layer vectors with hand-computed
// node outputs, a latency-configurable memory model and reset/sequence-error cases.
module tb_layer_datapath;

    localparam int NO_NPL = 4;
    localparam int NO_IPN = 4;
    localparam int DW     = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  arb_en;
    logic                  mac_en;
    logic                  bias_add_en;
    logic                  act_fn_en;
    logic [DW*NO_NPL-1:0]  bias_data;
    logic [DW*NO_NPL-1:0]  out_data;
    logic                  out_valid;
    logic                  seq_err;

    layer_datapath_if #(.NO_NPL(NO_NPL), .NO_IPN(NO_IPN), .DW(DW)) mem_bus ();

    layer_datapath #(.NO_NPL(NO_NPL), .NO_IPN(NO_IPN), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .arb_en      (arb_en),
        .mac_en      (mac_en),
        .bias_add_en (bias_add_en),
        .act_fn_en   (act_fn_en),
        .mem         (mem_bus),
        .bias_data   (bias_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .seq_err     (seq_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NO_IPN-1:0][DW-1:0] x;
        logic [NO_NPL-1:0][DW-1:0] wn;
        logic [NO_NPL-1:0][DW-1:0] bias;
        logic [NO_NPL-1:0][DW-1:0] want;
        logic [3:0]                lat;
        logic                      gaps;
        logic                      toggle;
    } vec_t;

    typedef struct {
        int addr;
        int ready;
    } req_t;

    vec_t vecs [7];
    req_t pend [$];

    logic [NO_IPN-1:0][DW-1:0] cur_x  = '0;
    logic [NO_NPL-1:0][DW-1:0] cur_wn = '0;
    int  lat       = 1;
    bit  gaps      = 1'b0;
    int  neg_cnt   = 0;
    int  rsp_sent  = 0;
    int  exp_addr  = 0;
    int  pass_cnt  = 0;
    int  total_cnt = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] want);
        total_cnt++;
        if (actual === want) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, want);
    endtask

    // Memory model: requests seen at a falling edge are answered lat cycles later, in order.
    always @(negedge clk) begin
        req_t r;
        neg_cnt++;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = '0;
        if (pend.size() > 0 && pend[0].ready <= neg_cnt && (!gaps || (neg_cnt % 2 == 0))) begin
            r = pend.pop_front();
            mem_bus.mem_rvalid = 1'b1;
            mem_bus.mem_rdata  = {cur_wn, cur_x[r.addr]};
            rsp_sent++;
        end
        if (mem_bus.mem_req === 1'b1) begin
            checkOutput("mem_addr", 64'(mem_bus.mem_addr), 64'(exp_addr));
            exp_addr++;
            r.addr  = int'(mem_bus.mem_addr);
            r.ready = neg_cnt + lat;
            pend.push_back(r);
        end
    end

    task automatic startLayer(input vec_t v);
        cur_x     = v.x;
        cur_wn    = v.wn;
        bias_data = v.bias;
        lat       = int'(v.lat);
        gaps      = v.gaps;
        exp_addr  = 0;
        rsp_sent  = 0;
        arb_en    = 1'b1;
        @(negedge clk);
        arb_en    = 1'b0;
    endtask

    task automatic waitFetch();
        for (int c = 0; c < 200 && rsp_sent < NO_IPN; c++) @(negedge clk);
        checkOutput("fetch_beats", 64'(rsp_sent), 64'(NO_IPN));
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int vi, input logic [DW*NO_NPL-1:0] prev_out,
                                 input bit want_err, input bit bad_act);
        vec_t v;
        v = vecs[vi];
        startLayer(v);
        checkOutput("valid_drop", 64'(out_valid), 64'd0);
        checkOutput("data_hold", 64'(out_data), 64'(prev_out));
        waitFetch();
        for (int i = 0; i < NO_IPN; i++) begin
            mac_en = 1'b1;
            @(negedge clk);
            if (v.toggle) begin
                mac_en = 1'b0;
                @(negedge clk);
                @(negedge clk);
            end
        end
        mac_en = 1'b0;
        for (int n = 0; n < NO_NPL; n++) begin
            bias_add_en = 1'b1;
            @(negedge clk);
            if (bad_act && n == 1) begin
                bias_add_en = 1'b0;
                act_fn_en   = 1'b1;
                @(negedge clk);
                act_fn_en   = 1'b0;
                checkOutput("bad_act_data", 64'(out_data), 64'(prev_out));
                checkOutput("bad_act_err", 64'(seq_err), 64'd1);
            end
        end
        bias_add_en = 1'b0;
        for (int n = 0; n < NO_NPL; n++) begin
            act_fn_en = 1'b1;
            @(negedge clk);
        end
        act_fn_en = 1'b0;
        checkOutput("out_valid", 64'(out_valid), 64'd1);
        for (int n = 0; n < NO_NPL; n++)
            checkOutput($sformatf("v%0d_node%0d", vi, n), 64'(out_data[n*DW +: DW]), 64'(v.want[n]));
        checkOutput("seq_err", 64'(seq_err), 64'(want_err));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_mem_req"}, 64'(mem_bus.mem_req), 64'd0);
        checkOutput({tag, "_mem_addr"}, 64'(mem_bus.mem_addr), 64'd0);
        checkOutput({tag, "_out_data"}, 64'(out_data), 64'd0);
        checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_seq_err"}, 64'(seq_err), 64'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // x, per-node weight (same for every input), bias, expected outputs; elements listed high index first
        vecs[0] = '{x: {8'd4, 8'd3, 8'd2, 8'd1}, wn: {4{8'd1}}, bias: '0,
                    want: {4{8'd10}}, lat: 4'd1, gaps: 1'b0, toggle: 1'b0};
        vecs[1] = '{x: {4{8'd127}}, wn: {4{8'd127}}, bias: {4{8'd127}},
                    want: {4{8'd127}}, lat: 4'd1, gaps: 1'b0, toggle: 1'b0};
        vecs[2] = '{x: {4{8'hFB}}, wn: {4{8'd1}}, bias: '0,
                    want: '0, lat: 4'd1, gaps: 1'b0, toggle: 1'b0};
        vecs[3] = '{x: {8'd4, 8'd3, 8'd2, 8'd1}, wn: {8'd3, 8'hFF, 8'd2, 8'd1},
                    bias: {8'hE2, 8'd20, 8'hFD, 8'd5},
                    want: {8'd0, 8'd10, 8'd17, 8'd15}, lat: 4'd2, gaps: 1'b0, toggle: 1'b0};
        vecs[4] = '{x: {8'd0, 8'd0, 8'd0, 8'd127}, wn: {8'hFF, 8'd1, 8'd1, 8'd1},
                    bias: {8'd127, 8'hFF, 8'd1, 8'd0},
                    want: {8'd0, 8'd126, 8'd127, 8'd127}, lat: 4'd1, gaps: 1'b0, toggle: 1'b0};
        vecs[5] = '{x: {4{8'h80}}, wn: {8'hFF, 8'd0, 8'd1, 8'h80},
                    bias: {8'h80, 8'd5, 8'd127, 8'h80},
                    want: {8'd127, 8'd5, 8'd0, 8'd127}, lat: 4'd1, gaps: 1'b0, toggle: 1'b0};
        vecs[6] = '{x: {8'd4, 8'd3, 8'd2, 8'd1}, wn: {4{8'd1}}, bias: '0,
                    want: {4{8'd10}}, lat: 4'd3, gaps: 1'b1, toggle: 1'b1};

        rst         = 1'b1;
        arb_en      = 1'b0;
        mac_en      = 1'b0;
        bias_add_en = 1'b0;
        act_fn_en   = 1'b0;
        bias_data   = '0;
        #2 rst = 1'b0;
        #1 checkResetOutputs("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] table vectors, back-to-back layers");
        applyStimulus(0, '0, 1'b0, 1'b0);
        for (int vi = 1; vi < 7; vi++) applyStimulus(vi, vecs[vi-1].want, 1'b0, 1'b0);

        $display("[TB] strobes in the wrong phase");
        #2 rst = 1'b0;
        #1 checkResetOutputs("rst_done");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mac_en = 1'b1;
        @(negedge clk);
        mac_en = 1'b0;
        checkOutput("idle_mac_err", 64'(seq_err), 64'd1);
        checkOutput("idle_mac_data", 64'(out_data), 64'd0);
        checkOutput("idle_mac_valid", 64'(out_valid), 64'd0);
        applyStimulus(0, '0, 1'b1, 1'b1);

        $display("[TB] reset during second MAC step");
        startLayer(vecs[0]);
        waitFetch();
        mac_en = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        #1 checkResetOutputs("mac_rst");
        mac_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(0, '0, 1'b0, 1'b0);

        $display("[TB] reset during fetch, late responses");
        lat      = 3;
        gaps     = 1'b0;
        exp_addr = 0;
        rsp_sent = 0;
        arb_en   = 1'b1;
        @(negedge clk);
        arb_en   = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1 checkResetOutputs("fetch_rst");
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) @(negedge clk);
        checkOutput("late_rsp_err", 64'(seq_err), 64'd1);
        checkOutput("late_rsp_valid", 64'(out_valid), 64'd0);
        checkOutput("late_rsp_data", 64'(out_data), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
